// File: rtl/hs_link_arbiter_pkg.sv
// Shared types and constants for the handshake link arbiter.
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    S_REQ = 2'd1,
    M_ACK = 2'd2
  } state_t;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hs_link_arbiter_if.sv
// Bundles the N master 4-phase channels and the single slave link.
// The slave modport is the arbiter's view; master is the environment side.
interface hs_link_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  import hs_arb_pkg::*;
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]              m_req;
  logic [N_REQ-1:0][DATA_W-1:0]  m_data;
  logic [N_REQ-1:0]              m_ack;
  logic                          s_req;
  logic [DATA_W-1:0]             s_data;
  logic                          s_ack;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;
  logic [N_REQ-1:0][CNT_W-1:0]   xfer_cnt;

  modport slave (
    input  m_req, m_data, s_ack,
    output m_ack, s_req, s_data, grant_id, busy, xfer_cnt
  );

  modport master (
    output m_req, m_data, s_ack,
    input  m_ack, s_req, s_data, grant_id, busy, xfer_cnt
  );
endinterface

// File: rtl/hs_link_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  win
);
  // Walk from the farthest offset down so the nearest requester is written last.
  always_comb begin
    valid = 1'b0;
    win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N_REQ;
      if (req[j]) begin
        valid = 1'b1;
        win   = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/hs_link_arbiter.sv
// N-to-1 4-phase handshake arbiter onto one slave link, round-robin grants.
// Define HS_ARB_STATS_EN to build saturating per-master transfer counters.
module hs_link_arbiter
  import hs_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  hs_link_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(N_REQ);

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     grant_id;
  logic [DATA_W-1:0]   s_data;
  logic                pick_vld;
  logic [ID_W-1:0]     pick_idx;
  logic                release_ok;
  logic [N_REQ-1:0]    m_ack;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req   (bus.m_req),
    .ptr   (ptr),
    .valid (pick_vld),
    .win   (pick_idx)
  );

  // Winner must have dropped its request and the slave its ack in the same cycle.
  assign release_ok = (state == M_ACK) && !bus.m_req[grant_id] && !bus.s_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      s_data   <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          grant_id <= pick_idx;
          s_data   <= bus.m_data[pick_idx];
          state    <= S_REQ;
        end
        S_REQ: if (bus.s_ack) state <= M_ACK;
        M_ACK: if (release_ok) begin
          state <= IDLE;
          ptr   <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only.
  always_comb begin
    m_ack = '0;
    if (state == M_ACK) m_ack[grant_id] = 1'b1;
  end

  assign bus.m_ack    = m_ack;
  assign bus.s_req    = (state == S_REQ);
  assign bus.s_data   = s_data;
  assign bus.grant_id = grant_id;
  assign bus.busy     = (state != IDLE);

`ifdef HS_ARB_STATS_EN
  logic [N_REQ-1:0][CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (release_ok && int'(grant_id) == i && cnt[i] != CNT_MAX)
          cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  assign bus.xfer_cnt = cnt;
`else
  assign bus.xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_hs_link_arbiter.sv
// Directed bench for hs_link_arbiter (N_REQ=4, DATA_W=8) with immediate assertions.
module tb_hs_link_arbiter;
  import hs_arb_pkg::*;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  hs_link_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  hs_link_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call one cycle after the grant: checks the grant, acks, releases.
  task automatic run_xfer(input int w, input bit rearm, input string tag);
    logic [N_REQ-1:0] onehot;
    onehot = '0;
    onehot[w] = 1'b1;
    chk({tag, " grant_id"}, 64'(bus.grant_id), 64'(w));
    chk({tag, " s_req"},    64'(bus.s_req), 64'd1);
    chk({tag, " s_data"},   64'(bus.s_data), 64'(bus.m_data[w]));
    bus.s_ack = 1'b1;
    tick();
    chk({tag, " m_ack"},    64'(bus.m_ack), 64'(onehot));
    chk({tag, " s_req low"}, 64'(bus.s_req), 64'd0);
    bus.m_req[w] = 1'b0;
    bus.s_ack = 1'b0;
    tick();
    chk({tag, " idle"},     64'(bus.busy), 64'd0);
    chk({tag, " ack clr"},  64'(bus.m_ack), 64'd0);
    if (rearm) bus.m_req[w] = 1'b1;
  endtask

  logic [15:0] exp_l1;

  initial begin
    bus.m_req  = '0;
    bus.s_ack  = 1'b0;
    bus.m_data = {8'h44, 8'hA3, 8'h22, 8'h11};

    // Reset values
    tick(); tick();
    chk("rst s_req",    64'(bus.s_req), 64'd0);
    chk("rst m_ack",    64'(bus.m_ack), 64'd0);
    chk("rst busy",     64'(bus.busy), 64'd0);
    chk("rst grant_id", 64'(bus.grant_id), 64'd0);
    chk("rst s_data",   64'(bus.s_data), 64'd0);
    chk("rst xfer_cnt", 64'(bus.xfer_cnt), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle stays",   64'(bus.busy), 64'd0);

    // Single master 2, slave acks 3 cycles after s_req
    bus.m_req = 4'b0100;
    tick();
    chk("sm s_req",     64'(bus.s_req), 64'd1);
    chk("sm s_data",    64'(bus.s_data), 64'hA3);
    chk("sm grant",     64'(bus.grant_id), 64'd2);
    chk("sm busy",      64'(bus.busy), 64'd1);
    tick(); tick();
    chk("sm wait s_req", 64'(bus.s_req), 64'd1);
    chk("sm wait m_ack", 64'(bus.m_ack), 64'd0);
    bus.s_ack = 1'b1;
    tick();
    chk("sm m_ack",     64'(bus.m_ack), 64'b0100);
    chk("sm s_req low", 64'(bus.s_req), 64'd0);
    bus.m_req = 4'b0000;
    tick();
    chk("sm hold ack",  64'(bus.m_ack), 64'b0100);
    bus.s_ack = 1'b0;
    tick();
    chk("sm idle",      64'(bus.busy), 64'd0);
    chk("sm m_ack clr", 64'(bus.m_ack), 64'd0);

    // All four requesting from reset: 0,1,2,3,0
    rst = 1'b1; tick(); rst = 1'b0;
    bus.m_req = 4'b1111;
    tick(); run_xfer(0, 1'b1, "rr0");
    tick(); run_xfer(1, 1'b1, "rr1");
    tick(); run_xfer(2, 1'b1, "rr2");
    tick(); run_xfer(3, 1'b1, "rr3");
    tick(); run_xfer(0, 1'b0, "rr4");
    bus.m_req = '0;
    tick();

    // Masters 1 and 3 with ptr=2: 3,1,3,1
    rst = 1'b1; tick(); rst = 1'b0;
    bus.m_req = 4'b0010;
    tick(); run_xfer(1, 1'b0, "alt setup");
    bus.m_req = 4'b1010;
    tick(); run_xfer(3, 1'b1, "alt3a");
    tick(); run_xfer(1, 1'b1, "alt1a");
    tick(); run_xfer(3, 1'b1, "alt3b");
    tick(); run_xfer(1, 1'b1, "alt1b");
    bus.m_req = '0;
    tick();

    // Reset while in S_REQ, then re-arbitrate from ptr 0
    bus.m_req = 4'b0100;
    tick();
    chk("abort pre s_req", 64'(bus.s_req), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort s_req",  64'(bus.s_req), 64'd0);
    chk("abort m_ack",  64'(bus.m_ack), 64'd0);
    chk("abort grant",  64'(bus.grant_id), 64'd0);
    chk("abort busy",   64'(bus.busy), 64'd0);
    bus.m_req = 4'b0110;
    tick(); run_xfer(1, 1'b0, "post abort");
    bus.m_req = '0;
    tick();

    // Master 0 drops its request mid-S_REQ (ptr=2 here)
    bus.m_req = 4'b0001;
    tick();
    chk("drop grant",   64'(bus.grant_id), 64'd0);
    bus.m_req = 4'b0000;
    tick();
    chk("drop s_req",   64'(bus.s_req), 64'd1);
    bus.s_ack = 1'b1;
    tick();
    chk("drop m_ack",   64'(bus.m_ack), 64'b0001);
    tick();
    chk("drop hold",    64'(bus.m_ack), 64'b0001);
    bus.s_ack = 1'b0;
    tick();
    chk("drop idle",    64'(bus.busy), 64'd0);

    // Three transfers by master 1
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      bus.m_req = 4'b0010;
      tick(); run_xfer(1, 1'b0, "cnt");
    end
`ifdef HS_ARB_STATS_EN
    exp_l1 = 16'd3;
`else
    exp_l1 = 16'd0;
`endif
    chk("cnt lane1",    64'(bus.xfer_cnt[1]), 64'(exp_l1));
    chk("cnt lane0",    64'(bus.xfer_cnt[0]), 64'd0);
    chk("cnt lane2",    64'(bus.xfer_cnt[2]), 64'd0);
    chk("cnt lane3",    64'(bus.xfer_cnt[3]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
